// File: rtl/riscv_bp_pkg.sv
// Shared types and constants for the BTB + 2-bit-counter branch predictor.
// Entry layout is sized from the core's address width and table depth.
package riscv_bp_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 64;
  localparam int BP_IDX     = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX - 2;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t CNT_SNT   = 2'b00;
  localparam bp_cnt_t CNT_WNT   = 2'b01;
  localparam bp_cnt_t CNT_WT    = 2'b10;
  localparam bp_cnt_t CNT_ST    = 2'b11;
  localparam bp_cnt_t CNT_ALLOC = CNT_WT;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    bp_cnt_t             cnt;
  } bp_entry_t;

  localparam bp_entry_t BP_ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
// force_st pins the counter to strongly-taken (unconditional jumps).
module bp_sat_counter
  import riscv_bp_pkg::*;
(
  input  bp_cnt_t cur,
  input  logic    taken,
  input  logic    force_st,
  output bp_cnt_t nxt
);

  always_comb begin
    // NOTE: assign a default first so no path leaves nxt unassigned and infers a latch.
    nxt = cur;
    if (force_st) begin
      nxt = CNT_ST;
    end else if (taken) begin
      if (cur != CNT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CNT_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: combinational lookup in IF,
// synchronous update from ID resolution, plus saturating perf counters.
module branch_predictor
  import riscv_bp_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES,
  parameter int PERF_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic              upd_is_jump,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  input  logic              clear,
  output logic              mispredict,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  // The entry struct is laid out from the package widths, so the table
  // geometry of an instance has to agree with them.
  if ((XLEN != BP_XLEN) || (ENTRIES != BP_ENTRIES)) begin : g_cfg_check
    $error("branch_predictor: XLEN/ENTRIES must match riscv_bp_pkg");
  end

  bp_entry_t        table_q [ENTRIES];
  logic [IDX-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  bp_entry_t        u_entry, u_new;
  logic             u_hit, u_write;
  bp_cnt_t          cnt_nxt;
  logic [3:0]       unused_pc_lsbs;

  assign unused_pc_lsbs = {fetch_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  assign f_idx       = fetch_pc[IDX+1:2];
  assign f_tag       = fetch_pc[XLEN-1:IDX+2];
  assign pred_hit    = table_q[f_idx].valid && (table_q[f_idx].tag == f_tag);
  assign pred_taken  = pred_hit && table_q[f_idx].cnt[1];
  assign pred_target = pred_taken ? table_q[f_idx].target : fetch_pc + XLEN'(4);

  assign u_idx   = upd_pc[IDX+1:2];
  assign u_tag   = upd_pc[XLEN-1:IDX+2];
  assign u_entry = table_q[u_idx];
  assign u_hit   = u_entry.valid && (u_entry.tag == u_tag);

  bp_sat_counter u_sat (
    .cur      (u_entry.cnt),
    .taken    (upd_taken),
    .force_st (upd_is_jump),
    .nxt      (cnt_nxt)
  );

  // A not-taken miss leaves the table alone so it never evicts an alias.
  assign u_write = upd_valid && (u_hit || upd_taken || upd_is_jump);

  always_comb begin
    u_new       = u_entry;
    u_new.valid = 1'b1;
    u_new.tag   = u_tag;
    if (upd_taken || upd_is_jump) u_new.target = upd_target;
    u_new.cnt   = (u_hit || upd_is_jump) ? cnt_nxt : CNT_ALLOC;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the whole table is reset (not just valid) so counters start at WNT
      // and no stale tag/target can leak out; this keeps it in flops, not SRAM.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BP_ENTRY_RST;
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (u_write) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      table_q[u_idx] <= u_new;
    end
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_valid && !(&perf_branches))
        perf_branches <= perf_branches + PERF_W'(1);
      if (mispredict && !(&perf_mispredicts))
        perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table of one-cycle vectors with a
// scoreboard queue, then perf saturation and asynchronous reset sequences.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_is_jump, upd_pred_taken, clear;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [3:0]  perf_branches, perf_mispredicts;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] fetch_pc;
    logic        uv;
    logic [31:0] upc;
    logic        utk, ujmp;
    logic [31:0] utgt;
    logic        uptk;
    logic [31:0] uptgt;
    logic        clr;
    logic        e_hit, e_taken;
    logic [31:0] e_target;
    logic        e_misp;
    logic [3:0]  e_br, e_mp;
  } vec_t;

  typedef struct {
    logic        hit, taken;
    logic [31:0] target;
    logic        misp;
    logic [3:0]  br, mp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  branch_predictor #(.XLEN(32), .ENTRIES(64), .PERF_W(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_pc         (fetch_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_is_jump      (upd_is_jump),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .clear            (clear),
    .mispredict       (mispredict),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
      input logic utk, input logic ujmp, input logic [31:0] utgt,
      input logic uptk, input logic [31:0] uptgt, input logic clr,
      input logic hit, input logic tk, input logic [31:0] tgt,
      input logic misp, input logic [3:0] br, input logic [3:0] mp);
    vec_t v;
    v.fetch_pc = fpc; v.uv = uv; v.upc = upc; v.utk = utk; v.ujmp = ujmp;
    v.utgt = utgt; v.uptk = uptk; v.uptgt = uptgt; v.clr = clr;
    v.e_hit = hit; v.e_taken = tk; v.e_target = tgt; v.e_misp = misp;
    v.e_br = br; v.e_mp = mp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fetch_pc = v.fetch_pc; upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.utk;
    upd_is_jump = v.ujmp; upd_target = v.utgt; upd_pred_taken = v.uptk;
    upd_pred_target = v.uptgt; clear = v.clr;
  endtask

  task automatic push_exp(input logic hit, input logic tk, input logic [31:0] tgt,
                          input logic misp, input logic [3:0] br, input logic [3:0] mp);
    exp_t e;
    e.hit = hit; e.taken = tk; e.target = tgt; e.misp = misp; e.br = br; e.mp = mp;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, " pred_hit"},         32'(pred_hit),         32'(e.hit));
    check({tag, " pred_taken"},       32'(pred_taken),       32'(e.taken));
    check({tag, " pred_target"},      pred_target,           e.target);
    check({tag, " mispredict"},       32'(mispredict),       32'(e.misp));
    check({tag, " perf_branches"},    32'(perf_branches),    32'(e.br));
    check({tag, " perf_mispredicts"}, 32'(perf_mispredicts), 32'(e.mp));
  endtask

  task automatic idle(input logic [31:0] fpc);
    fetch_pc = fpc; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_is_jump = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    upd_pred_target = '0; clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle(32'h0);

    //        fetch         uv upc     tk jmp utgt    ptk ptgt    clr hit tk tgt           m  br  mp
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h104, 0, 0, 0));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 0, 32'h80,  0, 32'h104, 0, 0, 0, 32'h104, 1, 0, 0));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h104, 1, 32'h80,  0, 1, 1, 32'h80,  1, 1, 1));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 0, 32'h104, 0, 32'h104, 0, 1, 0, 32'h104, 0, 2, 2));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h104, 0, 3, 2));
    vecs.push_back(mk(32'h200, 1, 32'h200, 0, 0, 32'h204, 0, 32'h204, 0, 0, 0, 32'h204, 0, 3, 2));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h104, 0, 4, 2));
    vecs.push_back(mk(32'h200, 1, 32'h200, 1, 0, 32'h40,  0, 32'h204, 0, 0, 0, 32'h204, 1, 4, 2));
    vecs.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h40,  0, 5, 3));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h104, 0, 5, 3));
    vecs.push_back(mk(32'h200, 1, 32'h200, 1, 0, 32'h44,  1, 32'h40,  0, 1, 1, 32'h40,  1, 5, 3));
    vecs.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h44,  0, 6, 4));
    vecs.push_back(mk(32'h200, 1, 32'h200, 1, 0, 32'h44,  1, 32'h44,  0, 1, 1, 32'h44,  0, 6, 4));
    vecs.push_back(mk(32'h200, 1, 32'h200, 0, 0, 32'h204, 1, 32'h44,  0, 1, 1, 32'h44,  1, 7, 4));
    vecs.push_back(mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h44,  0, 8, 5));
    vecs.push_back(mk(32'h300, 1, 32'h300, 1, 1, 32'h10,  0, 32'h304, 0, 0, 0, 32'h304, 1, 8, 5));
    vecs.push_back(mk(32'h300, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h10,  0, 9, 6));
    vecs.push_back(mk(32'h300, 1, 32'h300, 0, 0, 32'h304, 1, 32'h10,  1, 1, 1, 32'h10,  1, 9, 6));
    vecs.push_back(mk(32'h300, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h304, 0, 10, 7));
    vecs.push_back(mk(32'h300, 0, 32'h300, 1, 0, 32'h10,  0, 32'h304, 0, 0, 0, 32'h304, 0, 10, 7));
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0,   0, 10, 7));
    vecs.push_back(mk(32'h104, 1, 32'h104, 1, 0, 32'h800, 0, 32'h108, 0, 0, 0, 32'h108, 1, 10, 7));
    vecs.push_back(mk(32'h104, 1, 32'h104, 0, 0, 32'h108, 1, 32'h800, 0, 1, 1, 32'h800, 1, 11, 8));
    vecs.push_back(mk(32'h104, 1, 32'h104, 1, 1, 32'h900, 0, 32'h108, 0, 1, 0, 32'h108, 1, 12, 9));
    vecs.push_back(mk(32'h104, 1, 32'h104, 0, 0, 32'h108, 1, 32'h900, 0, 1, 1, 32'h900, 1, 13, 10));
    vecs.push_back(mk(32'h104, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h900, 0, 14, 11));

    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i]);
      push_exp(vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_target,
               vecs[i].e_misp, vecs[i].e_br, vecs[i].e_mp);
      #1;
      compare($sformatf("vec%0d", i));
    end

    // 20 mispredicting not-taken misses: counters must pin at 15 and hold.
    for (int i = 0; i < 20; i++) begin
      int eb, em;
      eb = (14 + i > 15) ? 15 : 14 + i;
      em = (11 + i > 15) ? 15 : 11 + i;
      @(negedge clock);
      idle(32'h104);
      upd_valid = 1'b1; upd_pc = 32'h400; upd_taken = 1'b0;
      upd_pred_taken = 1'b1; upd_pred_target = 32'h0;
      push_exp(1'b1, 1'b1, 32'h900, 1'b1, 4'(eb), 4'(em));
      #1;
      compare($sformatf("sat%0d", i));
    end
    @(negedge clock);
    idle(32'h104);
    push_exp(1'b1, 1'b1, 32'h900, 1'b0, 4'd15, 4'd15);
    #1;
    compare("sat_hold");

    // Allocate 0x600, then reset asynchronously while an update of 0x700 is pending.
    @(negedge clock);
    idle(32'h600);
    upd_valid = 1'b1; upd_pc = 32'h600; upd_taken = 1'b1; upd_target = 32'h20;
    upd_pred_target = 32'h604;
    @(negedge clock);
    idle(32'h600);
    upd_valid = 1'b1; upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'h30;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h704;
    push_exp(1'b1, 1'b1, 32'h20, 1'b1, 4'd15, 4'd15);
    #1;
    compare("pre_rst");
    #1;
    reset = 1'b0;
    push_exp(1'b0, 1'b0, 32'h604, 1'b1, 4'd0, 4'd0);
    #1;
    compare("async_rst");
    @(negedge clock);
    idle(32'h700);
    reset = 1'b1;
    push_exp(1'b0, 1'b0, 32'h704, 1'b0, 4'd0, 4'd0);
    #1;
    compare("rst_no_0x700");
    @(negedge clock);
    idle(32'h600);
    push_exp(1'b0, 1'b0, 32'h604, 1'b0, 4'd0, 4'd0);
    #1;
    compare("rst_no_0x600");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor for the pipelined RISC-V core. It combines a direct-mapped branch target buffer (BTB) with a 2-bit saturating-counter history table, and replaces the fixed predict-not-taken plus ControlBubble scheme. Lookup is combinational in IF from the fetch PC. Update is synchronous, driven by branch/jump resolution in ID. Saturating performance counters track resolved branches and mispredicts.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BTB/counter table depth; power of two, >= 2
PERF_W, 32, width of each performance counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_pc  input  XLEN  IF-stage PC to predict
pred_hit  output  1  valid entry with matching tag for fetch_pc
pred_taken  output  1  predicted taken
pred_target  output  XLEN  predicted next PC
upd_valid  input  1  resolved branch/jump present this cycle
upd_pc  input  XLEN  PC of the resolved instruction
upd_taken  input  1  actual outcome
upd_is_jump  input  1  unconditional (JAL/JALR)
upd_target  input  XLEN  actual target address
upd_pred_taken  input  1  prediction that was made for upd_pc (piped from IF)
upd_pred_target  input  XLEN  target that was predicted for upd_pc
clear  input  1  synchronous invalidate of all entries
mispredict  output  1  resolution disagrees with the prediction
perf_branches  output  PERF_W  count of upd_valid cycles
perf_mispredicts  output  PERF_W  count of mispredict cycles

Behaviour:
- IDX = log2(ENTRIES).
- Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2]. Each entry holds: valid, tag, target, 2-bit counter.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & (tag[idx] == fetch tag).
  - pred_taken = pred_hit & cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc + 4 (wraps mod 2^XLEN).
- Update (at posedge, when upd_valid=1 and clear=0):
  - Tag hit: counter saturating +1 if taken, -1 if not taken. Target overwritten with upd_target when taken.
  - Tag miss and taken: allocate or replace the entry. valid=1, tag, target written; counter=10.
  - Tag miss and not taken: no table change.
  - upd_is_jump: counter forced to 11 and target written, whether hit or miss.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents; there is no bypass. The new contents are visible on the next cycle.
- clear=1: all valid bits go to 0 at the next edge. Tags, targets and counters are left unchanged. clear has priority over a simultaneous update, which is dropped. Perf counters are unaffected by clear.
- mispredict (combinational) = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target))).
- Perf counters:
  - perf_branches +1 per upd_valid cycle.
  - perf_mispredicts +1 per mispredict cycle.
  - Both saturate at all-ones and do not wrap.
- Reset (reset=0, asynchronous):
  - All valid bits 0, tags/targets 0, counters 01, perf counters 0.
  - Outputs then read pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, mispredict follows its inputs.
  - Reset asserted mid-update aborts the write. No partial entry survives.
- Aliasing: PCs sharing an index but with different tags evict each other only through a taken update. A not-taken miss never evicts.

Decomposition:
- Package riscv_bp_pkg holds:
  - the counter-state constants SNT/WNT/WT/ST and the allocate value WT;
  - a typedef struct for a BTB entry (valid, tag, target, cnt), parametrised through localparam widths derived from XLEN/ENTRIES;
  - a typedef for the 2-bit counter.
- One sub-module, bp_sat_counter: combinational 2-bit saturating next-state, with inputs cur, taken, force_st and output nxt. It is instantiated once in the update path.

Test Plan:
- Reset, then lookup fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; perf counters 0.
- Update 0x100 taken, target 0x80, upd_pred_taken=0 -> mispredict=1 that cycle. The next cycle's lookup of 0x100 gives hit=1, taken=1, target=0x80, and perf_mispredicts=1.
- Two further not-taken updates of 0x100 -> counter goes 10->01->00. Lookup gives hit=1, taken=0, target=0x104.
- Aliasing with ENTRIES=64, 0x100 allocated: lookup 0x200 (same index 0) -> hit=0. A not-taken update of 0x200 leaves 0x100 hitting. A taken update of 0x200 (target 0x40) makes 0x200 hit and 0x100 miss.
- JAL update at 0x300, target 0x10 -> counter 11, taken=1 on lookup. Then assert clear together with an update of 0x300 -> next cycle hit=0 and the update is dropped.
- PERF_W=4: drive 20 mispredicting updates -> perf_mispredicts=15 and perf_branches=15, holding. Then assert reset mid-sequence -> all outputs return to reset values immediately, without waiting for a clock edge.
